// File: rtl/stb_pkg.sv
// Shared types for the strobe-period averaging block: FSM state and error codes.
package stb_pkg;

    localparam int T_CNT_WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        RELEASE = 3'd2,
        DONE    = 3'd3,
        FAIL    = 3'd4
    } stb_avg_state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_TO   = 2'd1,
        ERR_STB  = 2'd2,
        ERR_ZERO = 2'd3
    } err_code_t;

endpackage

// File: rtl/stb_minmax_acc.sv
// Running sum plus min/max trackers for period samples; clr_i preloads
// min to all-ones and max to zero so the first add sets both.
module stb_minmax_acc #(
    parameter int T_CNT_WIDTH = 32,
    parameter int LOG2_N      = 3
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    input  logic                          clr_i,
    input  logic                          add_i,
    input  logic [T_CNT_WIDTH-1:0]        sample_i,
    output logic [T_CNT_WIDTH+LOG2_N-1:0] acc_o,
    output logic [T_CNT_WIDTH-1:0]        min_o,
    output logic [T_CNT_WIDTH-1:0]        max_o
);

    localparam int ACC_W = T_CNT_WIDTH + LOG2_N;

    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [T_CNT_WIDTH-1:0] min_q, min_d;
    logic [T_CNT_WIDTH-1:0] max_q, max_d;

    always_comb begin
        acc_d = acc_q;
        min_d = min_q;
        max_d = max_q;
        if (clr_i) begin
            acc_d = '0;
            min_d = '1;
            max_d = '0;
        end else if (add_i) begin
            acc_d = acc_q + ACC_W'(sample_i);
            if (sample_i < min_q) min_d = sample_i;
            if (sample_i > max_q) max_d = sample_i;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            acc_q <= '0;
            min_q <= '0;
            max_q <= '0;
        end else begin
            acc_q <= acc_d;
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign acc_o = acc_q;
    assign min_o = min_q;
    assign max_o = max_q;

endmodule

// File: rtl/stb_period_avg.sv
// Collects 2^LOG2_N strobe-generator period samples and reports mean/min/max.
// Optional jitter reporting (max - min against a limit) under PERIOD_JITTER_EN.
module stb_period_avg
    import stb_pkg::*;
#(
    parameter int T_CNT_WIDTH = T_CNT_WIDTH_DEF,
    parameter int LOG2_N      = 3,
    parameter int TO_WIDTH    = 24
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [TO_WIDTH-1:0]    timeout_i,
    output logic                   stb_req_o,
    input  logic                   stb_valid_i,
    input  logic [T_CNT_WIDTH-1:0] stb_period_i,
    input  logic                   stb_err_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [1:0]             err_code_o,
    output logic [2:0]             state_o,
    output logic [T_CNT_WIDTH-1:0] avg_o,
    output logic [T_CNT_WIDTH-1:0] min_o,
`ifdef PERIOD_JITTER_EN
    input  logic [T_CNT_WIDTH-1:0] jit_lim_i,
    output logic [T_CNT_WIDTH-1:0] jit_o,
    output logic                   jit_err_o,
`endif
    output logic [T_CNT_WIDTH-1:0] max_o
);

    localparam int ACC_W = T_CNT_WIDTH + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(2 ** LOG2_N);

    stb_avg_state_t         state_q, state_d;
    logic [TO_WIDTH-1:0]    to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    err_code_t              fail_code_q, fail_code_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    err_code_t              err_code_q, err_code_d;
    logic [T_CNT_WIDTH-1:0] avg_q, avg_d;
    logic [T_CNT_WIDTH-1:0] min_q, min_d;
    logic [T_CNT_WIDTH-1:0] max_q, max_d;
    logic                   acc_clr, acc_add;
    logic [ACC_W-1:0]       acc;
    logic [T_CNT_WIDTH-1:0] run_min, run_max;
`ifdef PERIOD_JITTER_EN
    logic [T_CNT_WIDTH-1:0] jit_q, jit_d;
    logic                   jit_err_q, jit_err_d;
`endif

    stb_minmax_acc #(
        .T_CNT_WIDTH(T_CNT_WIDTH),
        .LOG2_N     (LOG2_N)
    ) u_acc (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .clr_i   (acc_clr),
        .add_i   (acc_add),
        .sample_i(stb_period_i),
        .acc_o   (acc),
        .min_o   (run_min),
        .max_o   (run_max)
    );

    // Handshake: stb_req_o is high only in REQ; a sample is taken on the first
    // REQ cycle with stb_valid_i, and the next request waits for valid to drop.
    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        cnt_d       = cnt_q;
        fail_code_d = fail_code_q;
        done_d      = 1'b0;
        err_d       = err_q;
        err_code_d  = err_code_q;
        avg_d       = avg_q;
        min_d       = min_q;
        max_d       = max_q;
        acc_clr     = 1'b0;
        acc_add     = 1'b0;
`ifdef PERIOD_JITTER_EN
        jit_d       = jit_q;
        jit_err_d   = jit_err_q;
`endif
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d     = REQ;
                        acc_clr     = 1'b1;
                        cnt_d       = '0;
                        to_cnt_d    = '0;
                        err_d       = 1'b0;
                        err_code_d  = ERR_NONE;
                        fail_code_d = ERR_NONE;
`ifdef PERIOD_JITTER_EN
                        jit_err_d   = 1'b0;
`endif
                    end
                end
                REQ: begin
                    to_cnt_d = to_cnt_q + TO_WIDTH'(1);
                    if (stb_err_i) begin
                        state_d     = FAIL;
                        fail_code_d = ERR_STB;
                    end else if (stb_valid_i) begin
                        if (stb_period_i == '0) begin
                            state_d     = FAIL;
                            fail_code_d = ERR_ZERO;
                        end else begin
                            acc_add = 1'b1;
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = RELEASE;
                        end
                    end else if (timeout_i != '0 && to_cnt_d == timeout_i) begin
                        state_d     = FAIL;
                        fail_code_d = ERR_TO;
                    end
                end
                RELEASE: begin
                    if (stb_err_i) begin
                        state_d     = FAIL;
                        fail_code_d = ERR_STB;
                    end else if (!stb_valid_i) begin
                        if (cnt_q < N_SAMPLES) begin
                            state_d  = REQ;
                            to_cnt_d = '0;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    avg_d   = acc[ACC_W-1:LOG2_N];
                    min_d   = run_min;
                    max_d   = run_max;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef PERIOD_JITTER_EN
                    jit_d     = run_max - run_min;
                    jit_err_d = (run_max - run_min) > jit_lim_i;
`endif
                end
                FAIL: begin
                    err_d      = 1'b1;
                    err_code_d = fail_code_q;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= IDLE;
            to_cnt_q    <= '0;
            cnt_q       <= '0;
            fail_code_q <= ERR_NONE;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            avg_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
`ifdef PERIOD_JITTER_EN
            jit_q       <= '0;
            jit_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            cnt_q       <= cnt_d;
            fail_code_q <= fail_code_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            avg_q       <= avg_d;
            min_q       <= min_d;
            max_q       <= max_d;
`ifdef PERIOD_JITTER_EN
            jit_q       <= jit_d;
            jit_err_q   <= jit_err_d;
`endif
        end
    end

    assign stb_req_o  = (state_q == REQ);
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign state_o    = state_q;
    assign avg_o      = avg_q;
    assign min_o      = min_q;
    assign max_o      = max_q;
`ifdef PERIOD_JITTER_EN
    assign jit_o      = jit_q;
    assign jit_err_o  = jit_err_q;
`endif

endmodule

// File: tb/tb_stb_period_avg.sv
// Directed bench for stb_period_avg with a strobe-generator model; covers
// PERIOD_JITTER_EN outputs when that macro is defined.
module tb_stb_period_avg;

    localparam int TW  = 32;
    localparam int L2N = 3;
    localparam int TOW = 24;

    logic           clk_i = 1'b0;
    logic           arst_i;
    logic           start_i;
    logic           abort_i;
    logic [TOW-1:0] timeout_i;
    logic           stb_req_o;
    logic           stb_valid_i;
    logic [TW-1:0]  stb_period_i;
    logic           stb_err_i;
    logic           busy_o;
    logic           done_o;
    logic           err_o;
    logic [1:0]     err_code_o;
    logic [2:0]     state_o;
    logic [TW-1:0]  avg_o;
    logic [TW-1:0]  min_o;
    logic [TW-1:0]  max_o;
`ifdef PERIOD_JITTER_EN
    logic [TW-1:0]  jit_lim_i;
    logic [TW-1:0]  jit_o;
    logic           jit_err_o;
`endif

    int errors = 0;
    int checks = 0;

    int req_rises  = 0;
    int req_hi_cnt = 0;
    int req_hi_run = 0;
    int done_cnt   = 0;
    bit gen_respond = 1'b1;
    int gen_lat     = 2;
    int gen_err_at  = 0;
    logic          req_prev = 1'b0;
    logic [TW-1:0] periods [8];

    stb_period_avg #(
        .T_CNT_WIDTH(TW),
        .LOG2_N     (L2N),
        .TO_WIDTH   (TOW)
    ) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .timeout_i   (timeout_i),
        .stb_req_o   (stb_req_o),
        .stb_valid_i (stb_valid_i),
        .stb_period_i(stb_period_i),
        .stb_err_i   (stb_err_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o),
        .state_o     (state_o),
        .avg_o       (avg_o),
        .min_o       (min_o),
`ifdef PERIOD_JITTER_EN
        .jit_lim_i   (jit_lim_i),
        .jit_o       (jit_o),
        .jit_err_o   (jit_err_o),
`endif
        .max_o       (max_o)
    );

    always #4 clk_i = ~clk_i;

    // Generator model: raises valid gen_lat cycles into a request, drops it
    // as soon as the request falls; optionally raises stb_err on one request.
    initial begin
        stb_valid_i  = 1'b0;
        stb_err_i    = 1'b0;
        stb_period_i = '0;
        forever begin
            @(negedge clk_i);
            if (done_o) done_cnt++;
            if (stb_req_o) begin
                req_hi_cnt++;
                if (!req_prev) begin
                    req_rises++;
                    req_hi_run = 0;
                end
                req_hi_run++;
                if (gen_respond && !stb_valid_i && req_hi_run > gen_lat) begin
                    stb_period_i = periods[(req_rises - 1) % 8];
                    stb_err_i    = (req_rises == gen_err_at);
                    stb_valid_i  = 1'b1;
                end
            end else begin
                stb_valid_i = 1'b0;
                stb_err_i   = 1'b0;
            end
            req_prev = stb_req_o;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done_o && n < budget) begin
            tick();
            n++;
        end
        chk({tag, " done"}, done_o, 1);
    endtask

    task automatic wait_rises(input int target, input int budget, input string tag);
        int n = 0;
        while (req_rises < target && n < budget) begin
            tick();
            n++;
        end
        chk({tag, " rises"}, (req_rises >= target), 1);
    endtask

    task automatic set_periods(input logic [TW-1:0] p);
        for (int i = 0; i < 8; i++) periods[i] = p;
    endtask

    task automatic chk_results(input string tag, input logic [TW-1:0] a,
                               input logic [TW-1:0] mn, input logic [TW-1:0] mx);
        chk({tag, " avg"}, avg_o, a);
        chk({tag, " min"}, min_o, mn);
        chk({tag, " max"}, max_o, mx);
    endtask

    initial begin
        arst_i    = 1'b1;
        start_i   = 1'b0;
        abort_i   = 1'b0;
        timeout_i = '0;
`ifdef PERIOD_JITTER_EN
        jit_lim_i = 3;
`endif
        set_periods(2500);

        repeat (3) tick();
        chk("rst req", stb_req_o, 0);
        chk("rst busy", busy_o, 0);
        chk("rst done", done_o, 0);
        chk("rst err", err_o, 0);
        chk("rst code", err_code_o, 0);
        chk("rst state", state_o, 0);
        chk_results("rst", 0, 0, 0);
        arst_i = 1'b0;
        tick();

        // Constant 2500 period, timeout disabled
        req_rises = 0;
        done_cnt  = 0;
        pulse_start();
        chk("t1 busy", busy_o, 1);
        chk("t1 req", stb_req_o, 1);
        wait_done(200, "t1");
        chk_results("t1", 2500, 2500, 2500);
        chk("t1 err", err_o, 0);
        chk("t1 code", err_code_o, 0);
        chk("t1 rises", req_rises, 8);
        chk("t1 busy end", busy_o, 0);
`ifdef PERIOD_JITTER_EN
        chk("t1 jit", jit_o, 0);
        chk("t1 jit_err", jit_err_o, 0);
`endif
        tick();
        chk("t1 done pulse", done_o, 0);
        chk("t1 done count", done_cnt, 1);

        // Spread samples: sum 20000 -> avg 2500
        periods[0] = 2498;
        periods[1] = 2502;
        req_rises  = 0;
        pulse_start();
        wait_done(200, "t2");
        chk_results("t2", 2500, 2498, 2502);
        chk("t2 err", err_o, 0);
`ifdef PERIOD_JITTER_EN
        chk("t2 jit", jit_o, 4);
        chk("t2 jit_err", jit_err_o, 1);
`endif

        // Valid arrives one cycle before the timeout would expire
        set_periods(2000);
        gen_lat   = 1;
        timeout_i = 3;
        pulse_start();
        wait_done(200, "t3");
        chk_results("t3", 2000, 2000, 2000);
        chk("t3 err", err_o, 0);

        // Generator never answers: timeout after 100 REQ cycles
        gen_respond = 1'b0;
        gen_lat     = 2;
        timeout_i   = 100;
        req_hi_cnt  = 0;
        done_cnt    = 0;
        pulse_start();
        wait_done(300, "t4");
        chk("t4 err", err_o, 1);
        chk("t4 code", err_code_o, 1);
        chk("t4 req", stb_req_o, 0);
        chk("t4 req cycles", req_hi_cnt, 100);
        chk("t4 done count", done_cnt, 1);
        chk_results("t4", 2000, 2000, 2000);

        // stb_err together with valid on the 4th request
        gen_respond = 1'b1;
        gen_err_at  = 4;
        set_periods(3000);
        req_rises = 0;
        pulse_start();
        chk("t5 err cleared", err_o, 0);
        wait_done(200, "t5");
        chk("t5 err", err_o, 1);
        chk("t5 code", err_code_o, 2);
        chk("t5 rises", req_rises, 4);
        chk_results("t5", 2000, 2000, 2000);
        gen_err_at = 0;
        pulse_start();
        chk("t5b err cleared", err_o, 0);
        chk("t5b code cleared", err_code_o, 0);
        wait_done(200, "t5b");
        chk_results("t5b", 3000, 3000, 3000);

        // Zero period on the 3rd sample
        periods[2] = 0;
        req_rises  = 0;
        pulse_start();
        wait_done(200, "t6");
        chk("t6 err", err_o, 1);
        chk("t6 code", err_code_o, 3);
        chk("t6 rises", req_rises, 3);
        chk_results("t6", 3000, 3000, 3000);

        // Abort during the 5th sample, then a clean run with an ignored start
        set_periods(2600);
        req_rises = 0;
        done_cnt  = 0;
        pulse_start();
        wait_rises(5, 100, "t7");
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("t7 busy", busy_o, 0);
        chk("t7 req", stb_req_o, 0);
        chk("t7 state", state_o, 0);
        repeat (4) tick();
        chk("t7 done count", done_cnt, 0);
        chk("t7 err", err_o, 0);
        chk_results("t7", 3000, 3000, 3000);
        req_rises = 0;
        pulse_start();
        wait_rises(2, 100, "t7b");
        pulse_start();
        wait_done(200, "t7b");
        chk_results("t7b", 2600, 2600, 2600);
        chk("t7b rises", req_rises, 8);
        chk("t7b done count", done_cnt, 1);
        chk("t7b err", err_o, 0);

        // Asynchronous reset in the middle of a request
        set_periods(2700);
        req_rises = 0;
        pulse_start();
        wait_rises(3, 100, "t8");
        chk("t8 req before", stb_req_o, 1);
        arst_i = 1'b1;
        #1;
        chk("t8 req", stb_req_o, 0);
        chk("t8 busy", busy_o, 0);
        chk("t8 done", done_o, 0);
        chk("t8 err", err_o, 0);
        chk_results("t8", 0, 0, 0);
        tick();
        arst_i = 1'b0;
        tick();
        req_rises = 0;
        done_cnt  = 0;
        pulse_start();
        wait_done(200, "t8b");
        chk_results("t8b", 2700, 2700, 2700);
        chk("t8b rises", req_rises, 8);
        chk("t8b err", err_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stb_period_avg.md
Name: stb_period_avg

Overview:
- Downstream consumer of the strobe generator's period measurement, in the measure unit.
- Runs the stb_req/stb_valid handshake 2^LOG2_N times and captures stb_period each time.
- Produces the mean, minimum and maximum period for the calibration software.
- Flags a timeout or generator error so firmware can abort a calibration step.

Parameters:
- T_CNT_WIDTH, 32, width of period samples and of min/max/avg outputs.
- LOG2_N, 3, log2 of samples per measurement (8 by default); legal range 0..8.
- TO_WIDTH, 24, width of the per-sample timeout counter.

Ports:
- clk_i  in  1  system clock.
- arst_i  in  1  asynchronous reset, active-high.
- start_i  in  1  one-cycle pulse; starts a measurement when idle, ignored when busy.
- abort_i  in  1  returns the FSM to IDLE next cycle; results are not updated.
- timeout_i  in  TO_WIDTH  maximum cycles to wait for stb_valid_i per sample; 0 disables the timeout.
- stb_req_o  out  1  request to the strobe generator.
- stb_valid_i  in  1  period valid, level; generator holds it while the request is high.
- stb_period_i  in  T_CNT_WIDTH  measured period in clk_i cycles.
- stb_err_i  in  1  generator error level.
- busy_o  out  1  measurement in progress.
- done_o  out  1  one-cycle pulse when results update.
- err_o  out  1  sticky error; cleared by the next start_i.
- err_code_o  out  2  0 = none, 1 = timeout, 2 = stb_err, 3 = zero period.
- avg_o  out  T_CNT_WIDTH  accumulator >> LOG2_N, truncated.
- min_o  out  T_CNT_WIDTH  minimum sample.
- max_o  out  T_CNT_WIDTH  maximum sample.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; accumulator and counters 0.
- FSM states: IDLE, REQ, RELEASE, DONE, FAIL.
- IDLE -> REQ on start_i. Clear accumulator, sample count, timeout counter, err_o and err_code_o. Preload min = all-ones, max = 0. busy_o = 1 from the next cycle.
- REQ: stb_req_o = 1; the timeout counter increments each cycle.
  - First cycle with stb_valid_i = 1: capture stb_period_i, add it to the accumulator (width T_CNT_WIDTH+LOG2_N, no overflow possible), update min/max, increment the count, go to RELEASE.
  - stb_period_i = 0 on capture -> FAIL, code 3.
- RELEASE: stb_req_o = 0; wait for stb_valid_i = 0 (at least one cycle in this state).
  - Then go to REQ if count < 2^LOG2_N, else DONE.
  - The timeout counter resets on entry to REQ.
- DONE: load avg_o, min_o, max_o together; done_o = 1 for one cycle; busy_o = 0 next cycle; return to IDLE.
- FAIL: stb_req_o = 0, err_o = 1, done_o = 1 for one cycle; result outputs keep their previous values; return to IDLE.
- Timeout: in REQ, when timeout_i != 0 and the counter reaches timeout_i -> FAIL, code 1.
- stb_err_i = 1 in REQ or RELEASE -> FAIL, code 2. It takes priority over a simultaneous stb_valid_i or timeout.
- Simultaneous events: abort_i has the highest priority (no done_o, no err_o). start_i while busy is ignored.
- Reset mid-operation: stb_req_o drops asynchronously; results clear to 0.
- Latency with an ideal generator (valid one cycle after req, low one cycle after release): about 2^LOG2_N * 3 + 2 cycles.
- Input timing: stb_valid_i and stb_period_i are synchronous to clk_i; no resynchronisation in this block.

Optional Feature:
- Macro PERIOD_JITTER_EN.
- When defined:
  - Extra input jit_lim_i [T_CNT_WIDTH].
  - Extra outputs jit_o [T_CNT_WIDTH] = max - min, loaded in DONE, and jit_err_o.
  - jit_err_o is set in DONE when jit_o > jit_lim_i. It does not force FAIL and is cleared by start_i.
- When undefined: the extra ports are absent; no subtractor or comparator.

Decomposition:
- Package stb_pkg:
  - T_CNT_WIDTH default.
  - enum stb_avg_state_t {IDLE, REQ, RELEASE, DONE, FAIL}.
  - enum err_code_t {ERR_NONE, ERR_TO, ERR_STB, ERR_ZERO}.
- Sub-module stb_minmax_acc (accumulator + min/max registers, clear/load strobes) is natural and kept separate.
- FSM and timeout logic stay in the top module.

Test Plan:
- Signal period 20000 ns at CLK_T 8 ns, LOG2_N = 3: model returns 2500 each time -> avg_o = min_o = max_o = 2500, done_o pulse, err_o = 0, exactly 8 stb_req_o rising edges.
- Samples 2498, 2502, 2500 x6 -> avg_o = 2500, min_o = 2498, max_o = 2502; with PERIOD_JITTER_EN and jit_lim_i = 3 -> jit_o = 4, jit_err_o = 1.
- Model never asserts stb_valid_i, timeout_i = 100 -> FAIL after 100 REQ cycles, err_code_o = 1, stb_req_o low, results unchanged.
- stb_err_i raised during the 4th REQ together with stb_valid_i -> err_code_o = 2, no accumulation of that sample; the next start_i clears err_o.
- abort_i in the 5th sample, then start_i -> busy_o low with no done_o; the fresh run completes normally with correct avg.
- arst_i asserted mid-REQ -> stb_req_o and busy_o go 0 immediately, outputs 0; the next start_i runs cleanly.
